// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: two-requester round-robin bus owner driving a registered 2:1 data mux
module mux_bus_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_HOLD   = 8,
  parameter int HOLD_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_sel,
  output logic [DATA_WIDTH-1:0] o_bus_out,
  output logic                  o_bus_valid
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t r_state, w_next, w_other;
  logic [HOLD_W-1:0] r_hold;
  logic r_prio, r_valid;
  logic [DATA_WIDTH-1:0] r_bus;
  logic w_own_req, w_oth_req, w_xfer, w_cap, w_enter;
  always_comb begin
    w_other   = r_state == OWN1 ? OWN0 : OWN1;
    w_own_req = r_state == OWN1 ? i_req1 : i_req0;
    w_oth_req = r_state == OWN1 ? i_req0 : i_req1;
    w_xfer    = r_state != IDLE && w_own_req;
    w_cap     = r_hold == HOLD_W'(MAX_HOLD - 1);
    w_next    = r_state == IDLE ? (i_req0 && i_req1 ? (r_prio ? OWN1 : OWN0) :
                                   i_req0 ? OWN0 : i_req1 ? OWN1 : IDLE) :
                !w_own_req ? (w_oth_req ? w_other : IDLE) :
                (w_cap && w_oth_req) ? w_other : r_state;
    w_enter   = w_next != IDLE && w_next != r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_prio  <= 1'b0;
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_xfer;
      if (w_xfer) r_bus <= r_state == OWN1 ? i_data1 : i_data0;
      if (w_enter) begin
        r_hold <= '0;
        r_prio <= w_next == OWN0;
      end else if (w_xfer && !w_cap) r_hold <= r_hold + HOLD_W'(1);
    end
  end
  assign o_gnt0      = r_state == OWN0;
  assign o_gnt1      = r_state == OWN1;
  assign o_sel       = r_state == OWN1;
  assign o_bus_out   = r_bus;
  assign o_bus_valid = r_valid;
endmodule
